// File: rtl/updown_mod_counter_if.sv
// Bundles the control inputs and status outputs of one up/down modulo counter
// stage so a stage can be handed around as a single port.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             terminal_count;
    logic             wrapped;

    modport master (
        output enable, up_down, load, load_value,
        input  count, at_max, at_zero, terminal_count, wrapped
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, at_max, at_zero, terminal_count, wrapped
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with clamped synchronous load, wrap or saturate
// behaviour at the boundaries, and a combinational terminal count for cascading.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_mod_counter_if.slave  bus
);

    // Boundary constants are one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : gBadModulus
        $error("updown_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH:0]   countExt;
    logic [WIDTH:0]   loadExt;
    logic             atMax;
    logic             atZero;

    assign countExt = {1'b0, count_q};
    assign loadExt  = {1'b0, bus.load_value};
    assign atMax    = (countExt == MAX_EXT);
    assign atZero   = (count_q == '0);

    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (bus.load) begin
            count_d = (loadExt < MOD_EXT) ? bus.load_value : MAX_VAL;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (!atMax) begin
                    count_d = count_q + 1'b1;
                end else if (SATURATE == 0) begin
                    count_d   = '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (!atZero) begin
                    count_d = count_q - 1'b1;
                end else if (SATURATE == 0) begin
                    count_d   = MAX_VAL;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.count          = count_q;
    assign bus.at_max         = atMax;
    assign bus.at_zero        = atZero;
    assign bus.wrapped        = wrapped_q;
    // Flags a boundary step attempt in both wrap and saturate modes.
    assign bus.terminal_count = bus.enable & (bus.up_down ? atMax : atZero) & ~bus.load;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench: wrap, saturate, full-range and cascaded
// counter instances driven from one linear stimulus sequence.
module tb_updown_mod_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(4)) ifA  ();
    updown_mod_counter_if #(.WIDTH(4)) ifS  ();
    updown_mod_counter_if #(.WIDTH(4)) ifF  ();
    updown_mod_counter_if #(.WIDTH(4)) ifLo ();
    updown_mod_counter_if #(.WIDTH(4)) ifHi ();

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dutA  (.clk(clk), .reset(reset), .bus(ifA));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dutS  (.clk(clk), .reset(reset), .bus(ifS));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dutF  (.clk(clk), .reset(reset), .bus(ifF));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dutLo (.clk(clk), .reset(reset), .bus(ifLo));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dutHi (.clk(clk), .reset(reset), .bus(ifHi));

    // The high digit steps only when the low digit hits its terminal count.
    assign ifHi.enable = ifLo.terminal_count;

    int totalChecks  = 0;
    int passedChecks = 0;
    int hiWraps      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic en, input logic up, input logic ld, input logic [3:0] val);
        ifA.enable     = en;
        ifA.up_down    = up;
        ifA.load       = ld;
        ifA.load_value = val;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ifA.enable = 1'b1; ifA.up_down = 1'b1; ifA.load = 1'b0; ifA.load_value = '0;
        ifS.enable = 1'b0; ifS.up_down = 1'b0; ifS.load = 1'b0; ifS.load_value = '0;
        ifF.enable = 1'b0; ifF.up_down = 1'b1; ifF.load = 1'b0; ifF.load_value = '0;
        ifLo.enable = 1'b0; ifLo.up_down = 1'b1; ifLo.load = 1'b0; ifLo.load_value = '0;
        ifHi.up_down = 1'b1; ifHi.load = 1'b0; ifHi.load_value = '0;
        tick();
        tick();
        checkOutput("reset_count", 32'(ifA.count), 0);
        checkOutput("reset_wrapped", 32'(ifA.wrapped), 0);
        checkOutput("reset_at_zero", 32'(ifA.at_zero), 1);

        $display("[TB] up count with wrap");
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkOutput($sformatf("up_count_%0d", i), 32'(ifA.count), 32'(i % 10));
            checkOutput($sformatf("up_wrapped_%0d", i), 32'(ifA.wrapped), 32'(i == 10));
            checkOutput($sformatf("up_tc_%0d", i), 32'(ifA.terminal_count), 32'(i == 9));
        end

        $display("[TB] down count with wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("down_count_1", 32'(ifA.count), 1);
        tick();
        checkOutput("down_count_0", 32'(ifA.count), 0);
        checkOutput("down_tc_at_0", 32'(ifA.terminal_count), 1);
        tick();
        checkOutput("down_wrap_count", 32'(ifA.count), 9);
        checkOutput("down_wrap_pulse", 32'(ifA.wrapped), 1);
        checkOutput("down_wrap_at_max", 32'(ifA.at_max), 1);
        tick();
        checkOutput("down_after_wrap", 32'(ifA.count), 8);
        checkOutput("down_pulse_clear", 32'(ifA.wrapped), 0);

        $display("[TB] saturate mode");
        ifS.enable = 1'b1; ifS.up_down = 1'b0;
        #1;
        checkOutput("sat_tc_down", 32'(ifS.terminal_count), 1);
        tick();
        checkOutput("sat_hold_zero", 32'(ifS.count), 0);
        checkOutput("sat_no_wrap_zero", 32'(ifS.wrapped), 0);
        ifS.load = 1'b1; ifS.load_value = 4'd9;
        tick();
        checkOutput("sat_load_9", 32'(ifS.count), 9);
        ifS.load = 1'b0; ifS.up_down = 1'b1;
        #1;
        checkOutput("sat_tc_up", 32'(ifS.terminal_count), 1);
        tick();
        checkOutput("sat_hold_max", 32'(ifS.count), 9);
        checkOutput("sat_no_wrap_max", 32'(ifS.wrapped), 0);

        $display("[TB] load and clamp");
        ifA.enable = 1'b1; ifA.up_down = 1'b1; ifA.load = 1'b1; ifA.load_value = 4'd7;
        #1;
        checkOutput("load_blocks_tc", 32'(ifA.terminal_count), 0);
        tick();
        checkOutput("load_7", 32'(ifA.count), 7);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd13);
        checkOutput("load_clamp", 32'(ifA.count), 9);
        checkOutput("load_no_wrap", 32'(ifA.wrapped), 0);

        $display("[TB] reset priority");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd6);
        checkOutput("load_6", 32'(ifA.count), 6);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5);
        checkOutput("reset_over_load", 32'(ifA.count), 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd8);
        checkOutput("load_8", 32'(ifA.count), 8);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("reset_over_count", 32'(ifA.count), 0);
        checkOutput("reset_over_count_wrapped", 32'(ifA.wrapped), 0);
        reset = 1'b0;

        $display("[TB] two-stage cascade");
        ifLo.enable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ifHi.wrapped) hiWraps++;
            if (i == 37) begin
                checkOutput("cascade_lo_37", 32'(ifLo.count), 7);
                checkOutput("cascade_hi_37", 32'(ifHi.count), 3);
            end
        end
        ifLo.enable = 1'b0;
        checkOutput("cascade_lo_100", 32'(ifLo.count), 0);
        checkOutput("cascade_hi_100", 32'(ifHi.count), 0);
        checkOutput("cascade_hi_wraps", 32'(hiWraps), 1);

        $display("[TB] direction toggle");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd4);
        checkOutput("toggle_load_4", 32'(ifA.count), 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i % 2 == 0), 1'b0, 4'd0);
            checkOutput($sformatf("toggle_%0d", i), 32'(ifA.count), (i % 2 == 0) ? 32'd5 : 32'd4);
        end

        $display("[TB] full-range modulus");
        ifF.load = 1'b1; ifF.load_value = 4'd15;
        tick();
        checkOutput("full_load_15", 32'(ifF.count), 15);
        checkOutput("full_at_max", 32'(ifF.at_max), 1);
        ifF.load = 1'b0; ifF.enable = 1'b1; ifF.up_down = 1'b1;
        tick();
        checkOutput("full_wrap_count", 32'(ifF.count), 0);
        checkOutput("full_wrap_pulse", 32'(ifF.wrapped), 1);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
